// File: rtl/blit_loop_seq.sv
// blit_loop_seq - blitter inner/outer loop sequencer.
//
// Owns the inner pixel counter and runs each row in this order: the inner
// run, then the optional A1 and A2 pointer-update phases, then the outer
// decrement. It drives the outer counter's decrement enable and reads back
// its zero flag to decide when the blit is finished.
//
// Optional feature: define LOOP_STOP_EN to add the stop/abort inputs.
//
// Ports:
//   sys_clk, reset      clock, asynchronous active-high reset
//   clk_en              advance enable; nothing changes while it is low
//   countld, gpu_din    count register write (gpu_din[ICNT_W-1:0] = inner count)
//   go, upda1, upda2    start a blit; per-row A1/A2 update enables (latched at go)
//   step, stepcnt       data path accepted a step consuming stepcnt pixels
//   outer0              outer counter is zero
//   stop, abort         (LOOP_STOP_EN only) freeze the inner run / cancel the blit
//   ocntena             one-cycle outer decrement enable
//   inner0, icount      inner count is zero / current inner count
//   a1upd, a2upd        one-cycle pointer update pulses
//   busy, done          not idle / one-cycle completion pulse
module blit_loop_seq #(
    parameter int ICNT_W = 16,
    parameter int STEP_W = 4
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              countld,
    input  logic [31:0]       gpu_din,
    input  logic              go,
    input  logic              upda1,
    input  logic              upda2,
    input  logic              step,
    input  logic [STEP_W-1:0] stepcnt,
    input  logic              outer0,
`ifdef LOOP_STOP_EN
    input  logic              stop,
    input  logic              abort,
`endif
    output logic              ocntena,
    output logic              inner0,
    output logic [ICNT_W-1:0] icount,
    output logic              a1upd,
    output logic              a2upd,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INNER = 3'd1,
        S_UPD1  = 3'd2,
        S_UPD2  = 3'd3,
        S_ODEC  = 3'd4,
        S_OCHK  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ICNT_W-1:0]   icount_q, icount_d;
    logic [ICNT_W-1:0]   iload_q, iload_d;
    logic                upd1_q, upd1_d;
    logic                upd2_q, upd2_d;
    logic                ocntena_q, ocntena_d;
    logic                a1upd_q, a1upd_d;
    logic                a2upd_q, a2upd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ICNT_W-1:0]   step_amt_s;

    // First state after the inner run (or in place of it for a zero-width row).
    function automatic state_t row_end_state(input logic u1, input logic u2);
        if (u1) begin
            return S_UPD1;
        end else if (u2) begin
            return S_UPD2;
        end else begin
            return S_ODEC;
        end
    endfunction

    // Pixels consumed by the current step; a stepcnt of zero still consumes one.
    always_comb begin
        step_amt_s = {{(ICNT_W-STEP_W){1'b0}}, stepcnt};
        if (stepcnt == {STEP_W{1'b0}}) begin
            step_amt_s = {{(ICNT_W-1){1'b0}}, 1'b1};
        end else begin
            step_amt_s = {{(ICNT_W-STEP_W){1'b0}}, stepcnt};
        end
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d  = state_q;
        icount_d = icount_q;
        iload_d  = iload_q;
        upd1_d   = upd1_q;
        upd2_d   = upd2_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    upd1_d = upda1;
                    upd2_d = upda2;
                    if (outer0) begin
                        done_d = 1'b1;               // zero rows: finish at once
                    end else if (iload_q == {ICNT_W{1'b0}}) begin
                        icount_d = iload_q;
                        state_d  = row_end_state(upda1, upda2);
                    end else begin
                        icount_d = iload_q;
                        state_d  = S_INNER;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INNER: begin
                // A count register write takes the cycle; the step is not applied.
                if (step && !countld) begin
                    if (step_amt_s >= icount_q) begin
                        icount_d = {ICNT_W{1'b0}};   // saturate instead of wrapping
                        state_d  = row_end_state(upd1_q, upd2_q);
                    end else begin
                        icount_d = icount_q - step_amt_s;
                    end
                end else begin
                    icount_d = icount_q;
                end
            end
            S_UPD1: begin
                state_d = upd2_q ? S_UPD2 : S_ODEC;
            end
            S_UPD2: begin
                state_d = S_ODEC;
            end
            S_ODEC: begin
                state_d = S_OCHK;
            end
            S_OCHK: begin
                // outer0 now reflects the decrement issued from S_ODEC.
                if (outer0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (iload_q == {ICNT_W{1'b0}}) begin
                    icount_d = iload_q;
                    state_d  = row_end_state(upd1_q, upd2_q);
                end else begin
                    icount_d = iload_q;
                    state_d  = S_INNER;
                end
            end
            default: begin
                state_d  = S_IDLE;
                icount_d = {ICNT_W{1'b0}};
            end
        endcase

        if (countld) begin
            iload_d = gpu_din[ICNT_W-1:0];
            if (state_q == S_IDLE) begin
                icount_d = gpu_din[ICNT_W-1:0];
            end else begin
                icount_d = icount_d;
            end
        end else begin
            iload_d = iload_q;
        end

`ifdef LOOP_STOP_EN
        // abort beats stop; neither produces a done pulse.
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            icount_d = iload_q;
            done_d   = 1'b0;
        end else if (stop && (state_q == S_INNER)) begin
            state_d  = S_INNER;
            icount_d = icount_q;
        end else begin
            state_d  = state_d;
        end
`endif

        // Pulses are Moore outputs of the next state, so each lasts one enabled cycle.
        ocntena_d = (state_d == S_ODEC);
        a1upd_d   = (state_d == S_UPD1);
        a2upd_d   = (state_d == S_UPD2);
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers; everything holds while clk_en is low.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            icount_q  <= {ICNT_W{1'b0}};
            iload_q   <= {ICNT_W{1'b0}};
            upd1_q    <= 1'b0;
            upd2_q    <= 1'b0;
            ocntena_q <= 1'b0;
            a1upd_q   <= 1'b0;
            a2upd_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (clk_en) begin
            state_q   <= state_d;
            icount_q  <= icount_d;
            iload_q   <= iload_d;
            upd1_q    <= upd1_d;
            upd2_q    <= upd2_d;
            ocntena_q <= ocntena_d;
            a1upd_q   <= a1upd_d;
            a2upd_q   <= a2upd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ocntena = ocntena_q;
    assign a1upd   = a1upd_q;
    assign a2upd   = a2upd_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign icount  = icount_q;
    assign inner0  = (icount_q == {ICNT_W{1'b0}});

endmodule
